// File: rtl/uart_pkg.sv
// Shared types and timing helpers for the configurable UART receiver.
//   parity_e    : parity mode encoding (matches the PARITY parameter values)
//   rx_state_e  : receiver frame FSM states
//   bit_clks()  : clocks per bit, rounded to nearest
//   half_clks() : clocks per half bit
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP      = 3'd4,
        ST_WAIT_HIGH = 3'd5
    } rx_state_e;

    function automatic int unsigned bit_clks(input int unsigned clk_rate,
                                             input int unsigned baud_rate);
        return (clk_rate + baud_rate / 2) / baud_rate;
    endfunction

    function automatic int unsigned half_clks(input int unsigned clk_rate,
                                              input int unsigned baud_rate);
        return bit_clks(clk_rate, baud_rate) / 2;
    endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period timer: counts 0..BIT_CLKS-1 and flags the last count as the bit tick.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : hold the counter at zero
//   load_half  : place the next tick HALF cycles from now (wins over clr)
//   tick_c     : one-cycle strobe on counter wrap
module uart_bit_timer #(
    parameter int unsigned BIT_CLKS = 868,
    parameter int unsigned HALF     = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load_half,
    output logic tick_c
);

    localparam int unsigned CNT_W = $clog2(BIT_CLKS);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_c = (cnt_q == CNT_W'(BIT_CLKS - 1));

    // Next count; loading BIT_CLKS-HALF makes the wrap land HALF cycles later.
    always_comb begin
        cnt_d = cnt_q + CNT_W'(1);
        if (load_half) begin
            cnt_d = CNT_W'(BIT_CLKS - HALF);
        end else if (clr || tick_c) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/odd/even parity, 1 or 2 stop
// bits) with false-start, parity, framing and break detection, edge resync of
// the bit clock, and a valid/ready output register with sticky overrun.
//   CLK_I, RST_NI  : clock, synchronous active-low reset
//   RX_I           : asynchronous serial input, idle high
//   DATA_O         : received word (LSB first on the line)
//   VALID_O/READY_I: output handshake
//   PARITY_ERR_O, FRAME_ERR_O : error flags belonging to the held word
//   OVERRUN_O      : frames dropped while a word was held (sticky until handshake)
//   BREAK_O        : one-cycle pulse on break detection
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int unsigned CLK_RATE    = 100_000_000,
    parameter int unsigned BAUD_RATE   = 115200,
    parameter int unsigned DATA_BITS   = 8,
    parameter int unsigned PARITY      = 0,
    parameter int unsigned STOP_BITS   = 1,
    parameter int unsigned SYNC_STAGES = 3
) (
    input  logic                 CLK_I,
    input  logic                 RST_NI,
    input  logic                 RX_I,
    output logic [DATA_BITS-1:0] DATA_O,
    output logic                 VALID_O,
    input  logic                 READY_I,
    output logic                 PARITY_ERR_O,
    output logic                 FRAME_ERR_O,
    output logic                 OVERRUN_O,
    output logic                 BREAK_O
);

    localparam int unsigned BIT_CLKS = bit_clks(CLK_RATE, BAUD_RATE);
    localparam int unsigned HALF     = half_clks(CLK_RATE, BAUD_RATE);
    localparam int unsigned NBIT_W   = $clog2(DATA_BITS);
    localparam parity_e     PAR_MODE = parity_e'(2'(PARITY));

    // Elaboration-time parameter legality checks.
    if (BIT_CLKS < 8) begin : g_bad_bit_clks
        $error("uart_rx_cfg: BIT_CLKS must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_rx_cfg: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
        $error("uart_rx_cfg: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_rx_cfg: STOP_BITS must be 1 or 2");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("uart_rx_cfg: SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   rx_prev_q;
    rx_state_e              state_q, state_d;
    logic [NBIT_W-1:0]      nbit_q, nbit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   par_bit_q, par_bit_d;
    logic                   stop2_q, stop2_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   ovr_q, ovr_d;
    logic                   brk_q, brk_d;

    logic rx_c, edge_c, fall_c, tick_c, clr_c, load_half_c;
    logic done_c, done_ferr_c, brk_c, par_err_c, hs_c;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], RX_I};
    assign rx_c   = sync_q[SYNC_STAGES-1];
    assign edge_c = rx_c ^ rx_prev_q;
    assign fall_c = rx_prev_q & ~rx_c;
    assign clr_c  = (state_q == ST_IDLE) || (state_q == ST_WAIT_HIGH);
    assign hs_c   = valid_q & READY_I;

    uart_bit_timer #(
        .BIT_CLKS (BIT_CLKS),
        .HALF     (HALF)
    ) u_timer (
        .clk       (CLK_I),
        .rst_n     (RST_NI),
        .clr       (clr_c),
        .load_half (load_half_c),
        .tick_c    (tick_c)
    );

    // Parity check over the assembled word and the captured parity bit.
    always_comb begin
        par_err_c = 1'b0;
        if (PAR_MODE == ODD) begin
            par_err_c = ~(^{shreg_q, par_bit_q});
        end else if (PAR_MODE == EVEN) begin
            par_err_c = ^{shreg_q, par_bit_q};
        end
    end

    // Frame FSM next state; data bits shift in from the MSB end so bit 0 lands at the LSB.
    always_comb begin
        state_d     = state_q;
        nbit_d      = nbit_q;
        shreg_d     = shreg_q;
        par_bit_d   = par_bit_q;
        stop2_d     = stop2_q;
        load_half_c = 1'b0;
        done_c      = 1'b0;
        done_ferr_c = 1'b0;
        brk_c       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fall_c) begin
                    state_d     = ST_START;
                    load_half_c = 1'b1;
                end
            end
            ST_START: begin
                if (tick_c) begin
                    state_d = rx_c ? ST_IDLE : ST_DATA;
                    nbit_d  = '0;
                end
            end
            ST_DATA: begin
                load_half_c = edge_c;
                if (tick_c) begin
                    shreg_d = {rx_c, shreg_q[DATA_BITS-1:1]};
                    if (nbit_q == NBIT_W'(DATA_BITS - 1)) begin
                        state_d = (PAR_MODE != NONE) ? ST_PARITY : ST_STOP;
                        stop2_d = 1'b0;
                    end else begin
                        nbit_d = nbit_q + NBIT_W'(1);
                    end
                end
            end
            ST_PARITY: begin
                load_half_c = edge_c;
                if (tick_c) begin
                    par_bit_d = rx_c;
                    state_d   = ST_STOP;
                    stop2_d   = 1'b0;
                end
            end
            ST_STOP: begin
                load_half_c = edge_c;
                if (tick_c) begin
                    if (stop2_q) begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end else if (!rx_c) begin
                        // Low first stop bit: break if everything else was low too.
                        if (shreg_q == '0 && (PAR_MODE == NONE || !par_bit_q)) begin
                            brk_c = 1'b1;
                        end else begin
                            done_c      = 1'b1;
                            done_ferr_c = 1'b1;
                        end
                        state_d = ST_WAIT_HIGH;
                    end else if (STOP_BITS == 2) begin
                        stop2_d = 1'b1;
                    end else begin
                        done_c  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_WAIT_HIGH: begin
                if (rx_c) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output register: load when empty or being drained, otherwise record overrun.
    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        ovr_d   = ovr_q;
        brk_d   = brk_c;
        if (hs_c) begin
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end
        if (done_c) begin
            if (!valid_q || READY_I) begin
                data_d  = shreg_q;
                perr_d  = par_err_c;
                ferr_d  = done_ferr_c;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            sync_q    <= '1;
            rx_prev_q <= 1'b1;
            state_q   <= ST_IDLE;
            nbit_q    <= '0;
            shreg_q   <= '0;
            par_bit_q <= 1'b0;
            stop2_q   <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
            brk_q     <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            rx_prev_q <= rx_c;
            state_q   <= state_d;
            nbit_q    <= nbit_d;
            shreg_q   <= shreg_d;
            par_bit_q <= par_bit_d;
            stop2_q   <= stop2_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
            brk_q     <= brk_d;
        end
    end

    assign DATA_O       = data_q;
    assign VALID_O      = valid_q;
    assign PARITY_ERR_O = perr_q;
    assign FRAME_ERR_O  = ferr_q;
    assign OVERRUN_O    = ovr_q;
    assign BREAK_O      = brk_q;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: two instances (8N1 and 7E2) at 32 clocks per bit.
module tb_uart_rx_cfg;

    localparam int unsigned CLK_RATE  = 3_200_000;
    localparam int unsigned BAUD_RATE = 100_000;
    localparam int          BIT       = 32;
    localparam int          BIT100    = 3200;

    typedef struct packed {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       ovr;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       rx_a, rx_b, ready_a, ready_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       valid_a, perr_a, ferr_a, ovr_a, brk_a;
    logic       valid_b, perr_b, ferr_b, ovr_b, brk_b;

    exp_t exp_a[$];
    exp_t exp_b[$];
    exp_t ea, eb;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_words_a = 0;
    int   n_words_b = 0;
    int   brk_cnt_a = 0;
    int   brk_cnt_b = 0;
    int   vcyc_a = 0;
    int   words_before;
    bit   abort = 1'b0;

    always #5 clk = ~clk;

    uart_rx_cfg #(
        .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(8),
        .PARITY(0), .STOP_BITS(1), .SYNC_STAGES(3)
    ) dut_a (
        .CLK_I(clk), .RST_NI(rst_n), .RX_I(rx_a), .DATA_O(data_a),
        .VALID_O(valid_a), .READY_I(ready_a), .PARITY_ERR_O(perr_a),
        .FRAME_ERR_O(ferr_a), .OVERRUN_O(ovr_a), .BREAK_O(brk_a)
    );

    uart_rx_cfg #(
        .CLK_RATE(CLK_RATE), .BAUD_RATE(BAUD_RATE), .DATA_BITS(7),
        .PARITY(2), .STOP_BITS(2), .SYNC_STAGES(3)
    ) dut_b (
        .CLK_I(clk), .RST_NI(rst_n), .RX_I(rx_b), .DATA_O(data_b),
        .VALID_O(valid_b), .READY_I(ready_b), .PARITY_ERR_O(perr_b),
        .FRAME_ERR_O(ferr_b), .OVERRUN_O(ovr_b), .BREAK_O(brk_b)
    );

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic set_rx(input int sel, input logic v);
        if (sel == 0) rx_a = v;
        else          rx_b = v;
    endtask

    task automatic push_a(input logic [8:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e = '{data: d, perr: pe, ferr: fe, ovr: ov};
        exp_a.push_back(e);
    endtask

    task automatic push_b(input logic [8:0] d, input logic pe, input logic fe, input logic ov);
        exp_t e;
        e = '{data: d, perr: pe, ferr: fe, ovr: ov};
        exp_b.push_back(e);
    endtask

    // Serialise one frame; per100 is the bit period in hundredths of a clock.
    task automatic tx(input int sel, input logic [8:0] d, input int nb, input int par,
                      input bit inv_par, input int nst, input bit stop_low, input int per100);
        logic bits[$];
        logic p;
        int   c0, c1;
        bits.push_back(1'b0);
        p = 1'b0;
        for (int i = 0; i < nb; i++) begin
            bits.push_back(d[i]);
            p = p ^ d[i];
        end
        if (par != 0) begin
            if (par == 1) p = ~p;
            bits.push_back(p ^ inv_par);
        end
        bits.push_back(~stop_low);
        if (nst == 2) bits.push_back(1'b1);
        for (int i = 0; i < bits.size(); i++) begin
            c0 = (i * per100) / 100;
            c1 = ((i + 1) * per100) / 100;
            set_rx(sel, bits[i]);
            for (int k = 0; k < c1 - c0; k++) begin
                if (abort) begin
                    set_rx(sel, 1'b1);
                    return;
                end
                step();
            end
        end
        set_rx(sel, 1'b1);
    endtask

    // Bounded wait for both scoreboards to empty.
    task automatic drain(input string name);
        for (int i = 0; i < 4 * BIT; i++) begin
            if (exp_a.size() == 0 && exp_b.size() == 0) break;
            step();
        end
        check({name, "_drain_a"}, 16'(exp_a.size()), 16'd0);
        check({name, "_drain_b"}, 16'(exp_b.size()), 16'd0);
    endtask

    // Monitor for instance a: every handshake pops and compares one expectation.
    always @(negedge clk) begin
        if (rst_n) begin
            if (brk_a) brk_cnt_a++;
            if (valid_a) vcyc_a++;
            if (valid_a && ready_a) begin
                n_words_a++;
                if (exp_a.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL a_unexpected_word: got %0h, expected no word", data_a);
                end else begin
                    ea = exp_a.pop_front();
                    check("a_data", 16'(data_a), 16'(ea.data));
                    check("a_perr", 16'(perr_a), 16'(ea.perr));
                    check("a_ferr", 16'(ferr_a), 16'(ea.ferr));
                    check("a_ovr",  16'(ovr_a),  16'(ea.ovr));
                end
            end
        end
    end

    // Monitor for instance b.
    always @(negedge clk) begin
        if (rst_n) begin
            if (brk_b) brk_cnt_b++;
            if (valid_b && ready_b) begin
                n_words_b++;
                if (exp_b.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL b_unexpected_word: got %0h, expected no word", data_b);
                end else begin
                    eb = exp_b.pop_front();
                    check("b_data", 16'(data_b), 16'(eb.data));
                    check("b_perr", 16'(perr_b), 16'(eb.perr));
                    check("b_ferr", 16'(ferr_b), 16'(eb.ferr));
                    check("b_ovr",  16'(ovr_b),  16'(eb.ovr));
                end
            end
        end
    end

    initial begin
        rst_n   = 1'b0;
        rx_a    = 1'b1;
        rx_b    = 1'b1;
        ready_a = 1'b1;
        ready_b = 1'b1;
        idle(3);
        check("rst_data_a",  16'(data_a),  16'd0);
        check("rst_valid_a", 16'(valid_a), 16'd0);
        check("rst_flags_a", 16'({perr_a, ferr_a, ovr_a, brk_a}), 16'd0);
        check("rst_valid_b", 16'(valid_b), 16'd0);
        rst_n = 1'b1;
        idle(5);

        // 8N1 clean word; valid high for exactly one cycle with ready held high
        push_a(9'h0A5, 1'b0, 1'b0, 1'b0);
        tx(0, 9'h0A5, 8, 0, 1'b0, 1, 1'b0, BIT100);
        idle(2 * BIT);
        drain("a5");
        check("a5_valid_cycles", 16'(vcyc_a), 16'd1);

        // 7E2: correct parity then inverted parity
        push_b(9'h035, 1'b0, 1'b0, 1'b0);
        tx(1, 9'h035, 7, 2, 1'b0, 2, 1'b0, BIT100);
        push_b(9'h035, 1'b1, 1'b0, 1'b0);
        tx(1, 9'h035, 7, 2, 1'b1, 2, 1'b0, BIT100);
        idle(2 * BIT);
        drain("par");

        // Framing error, then a 12-bit break
        push_a(9'h05A, 1'b0, 1'b1, 1'b0);
        tx(0, 9'h05A, 8, 0, 1'b0, 1, 1'b1, BIT100);
        idle(2 * BIT);
        drain("ferr");
        words_before = n_words_a;
        set_rx(0, 1'b0);
        idle(12 * BIT);
        set_rx(0, 1'b1);
        idle(2 * BIT);
        check("break_pulses", 16'(brk_cnt_a), 16'd1);
        check("break_no_word", 16'(n_words_a), 16'(words_before));

        // Short low glitch on an idle line is a false start
        words_before = n_words_a;
        set_rx(0, 1'b0);
        idle(10);
        set_rx(0, 1'b1);
        idle(15 * BIT);
        check("glitch_no_word", 16'(n_words_a), 16'(words_before));
        check("glitch_valid", 16'(valid_a), 16'd0);

        // +3% and -3% baud
        push_a(9'h0C3, 1'b0, 1'b0, 1'b0);
        tx(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b0, 3107);
        push_a(9'h0C3, 1'b0, 1'b0, 1'b0);
        tx(0, 9'h0C3, 8, 0, 1'b0, 1, 1'b0, 3299);
        idle(2 * BIT);
        drain("drift");

        // Overrun: second frame dropped while first is held
        ready_a = 1'b0;
        tx(0, 9'h011, 8, 0, 1'b0, 1, 1'b0, BIT100);
        idle(2 * BIT);
        check("ovr_held_valid", 16'(valid_a), 16'd1);
        tx(0, 9'h022, 8, 0, 1'b0, 1, 1'b0, BIT100);
        idle(2 * BIT);
        check("ovr_held_data", 16'(data_a), 16'h11);
        check("ovr_flag", 16'(ovr_a), 16'd1);
        push_a(9'h011, 1'b0, 1'b0, 1'b1);
        ready_a = 1'b1;
        step();
        check("ovr_cleared", 16'(ovr_a), 16'd0);
        check("ovr_valid_fell", 16'(valid_a), 16'd0);
        drain("ovr");

        // Reset during bit 4 with a pending word; both must vanish
        ready_a = 1'b0;
        tx(0, 9'h03C, 8, 0, 1'b0, 1, 1'b0, BIT100);
        idle(2 * BIT);
        check("pend_valid", 16'(valid_a), 16'd1);
        fork
            tx(0, 9'h096, 8, 0, 1'b0, 1, 1'b0, BIT100);
            begin
                idle(4 * BIT + BIT / 2);
                abort = 1'b1;
                rst_n = 1'b0;
                step();
                check("midrst_valid", 16'(valid_a), 16'd0);
                check("midrst_data", 16'(data_a), 16'd0);
                step();
                rst_n = 1'b1;
            end
        join
        abort   = 1'b0;
        ready_a = 1'b1;
        words_before = n_words_a;
        idle(12 * BIT);
        check("midrst_no_word", 16'(n_words_a), 16'(words_before));
        push_a(9'h07E, 1'b0, 1'b0, 1'b0);
        tx(0, 9'h07E, 8, 0, 1'b0, 1, 1'b0, BIT100);
        idle(2 * BIT);
        drain("7e");

        check("final_break_a", 16'(brk_cnt_a), 16'd1);
        check("final_break_b", 16'(brk_cnt_b), 16'd0);
        check("final_words_b", 16'(n_words_b), 16'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_cfg.md
Name: uart_rx_cfg

Overview:
Parametrised successor to the fixed 8N1 debug-link UART receiver. It supports 5..9 data bits, optional odd/even parity and 1 or 2 stop bits. It detects false starts, parity errors, framing errors and line breaks, and resynchronises its bit clock on RX edges. Received words are presented on a valid/ready output register with overrun reporting, so the DMI/debug FIFO side can apply back-pressure.

Parameters:
CLK_RATE, 100_000_000, system clock in Hz
BAUD_RATE, 115200, line rate in baud
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, 1 or 2
SYNC_STAGES, 3, RX synchroniser depth, at least 2

Ports:
CLK_I  in  1  system clock
RST_NI  in  1  reset; one clock; reset is synchronous and active-low
RX_I  in  1  asynchronous serial line, idle high
DATA_O  out  DATA_BITS  received word, LSB first on the line
VALID_O  out  1  DATA_O and error flags are valid
READY_I  in  1  consumer accepts the word when VALID_O and READY_I are both high
PARITY_ERR_O  out  1  parity mismatch on the held word
FRAME_ERR_O  out  1  first stop bit sampled low on the held word
OVERRUN_O  out  1  one or more frames were dropped while VALID_O was high
BREAK_O  out  1  single-cycle pulse when a break is detected

Behaviour:
- Reset: all outputs 0, DATA_O 0, FSM in IDLE, synchroniser filled with 1s.
- RX passes through SYNC_STAGES flops. rx_prev is that value delayed by one more cycle. An edge is defined as rx != rx_prev.
- Timing constants: BIT_CLKS = round(CLK_RATE/BAUD_RATE), HALF = BIT_CLKS/2. Elaboration fails if BIT_CLKS < 8.
- Bit timer: counter counts 0..BIT_CLKS-1, and tick is asserted for one cycle on wrap.
  - Timer is held cleared in IDLE.
  - On entry to START it is loaded so the first tick falls HALF cycles after the falling edge.
  - Any edge in DATA, PARITY or STOP reloads the counter so the next tick falls HALF cycles later (mid-bit resync).
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH.
  - IDLE -> START on a falling edge.
  - START, on tick: if rx = 1 it is a false start, go to IDLE with no flags; else go to DATA with nbit = 0.
  - DATA, on tick: shift rx into bit nbit. After nbit = DATA_BITS-1, go to PARITY if PARITY != 0, else STOP.
  - PARITY, on tick: capture the parity bit, then go to STOP. Odd parity requires XOR(data, parity) = 1; even requires 0.
  - STOP, on tick: sample the stop bit. With STOP_BITS = 2, only the first stop bit is checked; the second bit time is still waited out before completion.
  - Completion: the frame completes on the last stop tick (the first stop tick when a framing error is detected).
  - Break: all data bits = 0, parity bit = 0 (if present), and first stop bit = 0. Then pulse BREAK_O for one cycle, deliver no word, go to WAIT_HIGH.
  - Framing error (stop bit = 0, not a break): deliver the word with FRAME_ERR_O = 1, go to WAIT_HIGH.
  - Normal completion: go to IDLE.
  - WAIT_HIGH -> IDLE once rx = 1.
- Output register:
  - When VALID_O = 0, a completed frame loads DATA_O, PARITY_ERR_O and FRAME_ERR_O, and VALID_O rises the cycle after the completing tick.
  - The word is held stable until the handshake. VALID_O falls the cycle after VALID_O & READY_I.
  - A completion in the same cycle as the handshake loads the new word, and VALID_O stays high.
  - A completion while VALID_O = 1 and READY_I = 0 discards the new frame and sets OVERRUN_O. OVERRUN_O is sticky and clears on the next handshake. The held word is unchanged.
- Reset mid-frame: FSM returns to IDLE, any pending word is lost, all outputs clear the next cycle.
- RX_I activity during reset is ignored.

Decomposition:
- uart_pkg: parity_e (NONE, ODD, EVEN), rx_state_e, bit_clks() and half_clks() constant functions.
- Existing baud_pkg helpers are reused where rates match.
- Sub-module uart_bit_timer: counter with clear, load-half and resync inputs and a tick output. The FSM and output register stay in uart_rx_cfg.

Test Plan:
- Default 8N1 at 100 MHz/115200 (BIT_CLKS = 868), send 0xA5, READY_I = 1 -> VALID_O for one cycle, DATA_O = 0xA5, all error flags 0.
- DATA_BITS = 7, PARITY = 2, STOP_BITS = 2, send 0x35 with correct parity, then 0x35 with parity inverted -> first word PARITY_ERR_O = 0, second word PARITY_ERR_O = 1 with DATA_O = 0x35.
- Send 0x5A with the stop bit forced low for one bit time -> FRAME_ERR_O = 1, DATA_O = 0x5A, FSM waits for the line to return high. Hold RX low for 12 bit times -> one BREAK_O pulse, VALID_O stays 0.
- 400-cycle low glitch on an idle line -> no VALID_O. Send 0xC3 at baud +3% and then -3% -> both received correctly thanks to edge resync.
- Hold READY_I = 0, send 0x11 then 0x22 -> DATA_O stays 0x11 and OVERRUN_O = 1. Raise READY_I -> handshake occurs, OVERRUN_O clears, no 0x22 is delivered.
- Assert RST_NI low during bit 4 of a frame, then release and send 0x7E -> no partial word appears, and 0x7E is received cleanly.
